// File: rtl/c_prng_share_pkg.sv
// Shared definitions for c_prng_share: FSM encodings, feedback tap generator,
// and counter sizing helper.
package c_prng_share_pkg;

    localparam logic [1:0] ST_WARMUP = 2'b00;
    localparam logic [1:0] ST_RUN    = 2'b01;

    // Tap mask for a Fibonacci LFSR; bit i selects stage q[i]. Odd index picks the reciprocal polynomial.
    function automatic logic [31:0] fbgen(input int width, input int index);
        logic [31:0] base;
        logic [31:0] mir;
        case (width)
            2:       base = 32'h0000_0003;
            3:       base = 32'h0000_0006;
            4:       base = 32'h0000_000C;
            5:       base = 32'h0000_0014;
            6:       base = 32'h0000_0030;
            7:       base = 32'h0000_0060;
            8:       base = 32'h0000_00B8;
            default: base = (32'h1 << (width - 1)) | (32'h1 << (width - 2));
        endcase
        mir = 32'h1 << (width - 1);
        for (int j = 0; j < width - 1; j++) begin
            if (base[j]) mir[width - 2 - j] = 1'b1;
        end
        return (index % 2 == 0) ? base : mir;
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/c_prng_rr_pick.sv
// Combinational round-robin pick: first set req at or after ptr, wrapping,
// returned as one-hot gnt plus encoded index.
module c_prng_rr_pick #(
    parameter int num_ports = 3,
    parameter int ptr_w     = 2
) (
    input  logic [0:num_ports-1] req,
    input  logic [ptr_w-1:0]     ptr,
    output logic [0:num_ports-1] gnt,
    output logic [ptr_w-1:0]     idx,
    output logic                 any
);

    always_comb begin
        int p;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        p   = 0;
        for (int k = 0; k < num_ports; k++) begin
            p = int'(ptr) + k;
            if (p >= num_ports) p = p - num_ports;
            if (!any && req[p]) begin
                any    = 1'b1;
                gnt[p] = 1'b1;
                idx    = ptr_w'(p);
            end
        end
    end

endmodule

// File: rtl/c_prng_share.sv
// One LFSR shared round-robin among num_ports requesters, with seeding and warm-up.
// Optional all-zero lockup recovery is built when C_PRNG_SHARE_LOCKUP_EN is defined.
module c_prng_share
    import c_prng_share_pkg::*;
#(
    parameter int               width        = 4,
    parameter int               index        = 0,
    parameter int               complete     = 0,
    parameter int               num_ports    = 3,
    parameter int               warmup_steps = 4,
    parameter logic [0:width-1] reset_seed   = '1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 seed_load,
    input  logic [0:width-1]     seed_val,
    input  logic [0:num_ports-1] req,
    output logic [0:num_ports-1] gnt,
    output logic [0:width-1]     rnd,
    output logic                 ready,
`ifdef C_PRNG_SHARE_LOCKUP_EN
    output logic                 lockup,
`endif
    output logic [1:0]           state_dbg
);

    localparam int                ptr_w     = (num_ports > 1) ? $clog2(num_ports) : 1;
    localparam int                wcnt_w    = cnt_width(warmup_steps);
    localparam logic [wcnt_w-1:0] wcnt_init = wcnt_w'(warmup_steps);
    localparam logic [31:0]       taps      = fbgen(width, index);

    logic [1:0]           state;
    logic [0:width-1]     q;
    logic [0:width-1]     q_step;
    logic [wcnt_w-1:0]    wcnt;
    logic [ptr_w-1:0]     ptr;
    logic [ptr_w-1:0]     ptr_nxt;
    logic [ptr_w-1:0]     pick_idx;
    logic                 pick_any;
    logic [0:num_ports-1] req_eff;
    logic                 grant_en;
    logic                 zero_det;
    logic                 recover;
    logic                 fb;

`ifdef C_PRNG_SHARE_LOCKUP_EN
    logic lockup_q;

    // Only a non-complete LFSR can get stuck at zero.
    assign zero_det = (complete == 0) && (q == '0);
    assign recover  = zero_det && !seed_load;
    assign lockup   = lockup_q;

    always_ff @(posedge clk) begin
        if (reset) lockup_q <= 1'b0;
        else       lockup_q <= recover;
    end
`else
    assign zero_det = 1'b0;
    assign recover  = 1'b0;
`endif

    // Complete mode flips feedback when all stages but the last are zero, splicing in the all-zero state.
    always_comb begin
        fb = 1'b0;
        for (int i = 0; i < width; i++) begin
            if (taps[i]) fb = fb ^ q[i];
        end
        if (complete != 0) fb = fb ^ (q[0:width-2] == '0);
        q_step = {fb, q[0:width-2]};
    end

    assign grant_en  = (state == ST_RUN) && !reset && !seed_load && !zero_det;
    assign req_eff   = grant_en ? req : '0;
    assign ready     = (state == ST_RUN) && !reset;
    assign rnd       = q;
    assign state_dbg = state;

    c_prng_rr_pick #(
        .num_ports(num_ports),
        .ptr_w    (ptr_w)
    ) u_pick (
        .req(req_eff),
        .ptr(ptr),
        .gnt(gnt),
        .idx(pick_idx),
        .any(pick_any)
    );

    assign ptr_nxt = (pick_idx == ptr_w'(num_ports - 1)) ? '0 : pick_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_WARMUP;
            q     <= reset_seed;
            wcnt  <= wcnt_init;
            ptr   <= '0;
        end else if (seed_load) begin
            state <= ST_WARMUP;
            q     <= seed_val;
            wcnt  <= wcnt_init;
        end else if (recover) begin
            state <= ST_WARMUP;
            q     <= reset_seed;
            wcnt  <= wcnt_init;
        end else if (state == ST_WARMUP) begin
            if (wcnt == '0) begin
                state <= ST_RUN;
            end else begin
                q    <= q_step;
                wcnt <= wcnt - 1'b1;
            end
        end else if (pick_any) begin
            q   <= q_step;
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: tb/tb_c_prng_share.sv
// Self-checking bench for c_prng_share (width=4, num_ports=3, warmup_steps=4, seed 4'hF)
// against an integer-level reference model of the sharing rules.
module tb_c_prng_share;

`ifdef C_PRNG_SHARE_LOCKUP_EN
    localparam bit lock_en = 1'b1;
`else
    localparam bit lock_en = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       seed_load;
    logic [0:3] seed_val;
    logic [0:2] req;
    logic [0:2] gnt;
    logic [0:3] rnd;
    logic       ready;
    logic [1:0] state_dbg;
`ifdef C_PRNG_SHARE_LOCKUP_EN
    logic       lockup;
`endif

    int n_checks;
    int n_fail;

    // reference model state
    bit m_run;
    int m_lfsr;
    int m_wcnt;
    int m_ptr;
    bit m_lock;

    c_prng_share #(
        .width       (4),
        .index       (0),
        .complete    (0),
        .num_ports   (3),
        .warmup_steps(4),
        .reset_seed  (4'hF)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .seed_load(seed_load),
        .seed_val (seed_val),
        .req      (req),
        .gnt      (gnt),
        .rnd      (rnd),
        .ready    (ready),
`ifdef C_PRNG_SHARE_LOCKUP_EN
        .lockup   (lockup),
`endif
        .state_dbg(state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Polynomial x^4+x^3+1; v holds stage 0 in bit 3, so the new bit enters at the top.
    function automatic int lfsr_next(input int v);
        return ((((v ^ (v >> 1)) & 1) << 3) | (v >> 1));
    endfunction

    // One clock: drive inputs, check combinational and state outputs, advance model at the edge.
    task automatic cycle(input bit rst, input bit sl, input int sv, input int rq,
                         output logic [31:0] g_obs);
        bit en;
        int gidx;
        int exp_g;
        reset     = rst;
        seed_load = sl;
        seed_val  = 4'(sv);
        req       = 3'(rq);
        #1;
        en    = !rst && m_run && !sl && !(lock_en && m_lfsr == 0);
        gidx  = -1;
        exp_g = 0;
        if (en) begin
            for (int k = 0; k < 3; k++) begin
                int p;
                p = (m_ptr + k) % 3;
                if (gidx < 0 && ((rq >> (2 - p)) & 1) == 1) gidx = p;
            end
        end
        if (gidx >= 0) exp_g = 1 << (2 - gidx);
        g_obs = 32'(gnt);
        check("gnt", 32'(gnt), 32'(exp_g));
        check("ready", 32'(ready), 32'(!rst && m_run));
        if (!rst) begin
            check("rnd", 32'(rnd), 32'(m_lfsr));
`ifdef C_PRNG_SHARE_LOCKUP_EN
            check("lockup", 32'(lockup), 32'(m_lock));
`endif
        end
        @(posedge clk);
        m_lock = 1'b0;
        if (rst) begin
            m_run = 1'b0; m_lfsr = 15; m_wcnt = 4; m_ptr = 0;
        end else if (sl) begin
            m_run = 1'b0; m_lfsr = sv & 15; m_wcnt = 4;
        end else if (lock_en && m_lfsr == 0) begin
            m_run = 1'b0; m_lfsr = 15; m_wcnt = 4; m_lock = 1'b1;
        end else if (!m_run) begin
            if (m_wcnt == 0) m_run = 1'b1;
            else begin
                m_lfsr = lfsr_next(m_lfsr);
                m_wcnt = m_wcnt - 1;
            end
        end else if (gidx >= 0) begin
            m_lfsr = lfsr_next(m_lfsr);
            m_ptr  = (gidx + 1) % 3;
        end
        #1;
    endtask

    initial begin
        logic [31:0] g;
        int s2[6] = '{4, 2, 1, 4, 2, 1};
        int s3[2] = '{1, 4};
        n_checks = 0;
        n_fail   = 0;
        m_run = 1'b0; m_lfsr = 15; m_wcnt = 4; m_ptr = 0; m_lock = 1'b0;
        reset = 1'b1; seed_load = 1'b0; seed_val = '0; req = '0;

        // 1: reset then warm-up; ready on the 5th edge with 4 steps from 4'hF
        cycle(1, 0, 0, 0, g);
        cycle(1, 0, 0, 0, g);
        check("t1_rst_rnd", 32'(rnd), 32'hF);
        check("t1_rst_ready", 32'(ready), 32'h0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, g);
        check("t1_ready", 32'(ready), 32'h1);
        check("t1_rnd", 32'(rnd), 32'h8);

        // 2: all requesting rotates 0,1,2,0,1,2
        for (int i = 0; i < 6; i++) begin
            cycle(0, 0, 0, 3'b111, g);
            check("t2_gnt_seq", g, 32'(s2[i]));
        end

        // 3: single requester, then ports 0 and 2 from pointer 2
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 0, 3'b010, g);
            check("t3_gnt_single", g, 32'h2);
        end
        for (int i = 0; i < 2; i++) begin
            cycle(0, 0, 0, 3'b101, g);
            check("t3_gnt_wrap", g, 32'(s3[i]));
        end
        cycle(0, 0, 0, 0, g);

        // 4: seed load during a grant cycle
        cycle(0, 1, 5, 3'b111, g);
        check("t4_gnt_blocked", g, 32'h0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 3'b111, g);
        check("t4_ready", 32'(ready), 32'h1);
        check("t4_rnd", 32'(rnd), 32'hF);

        // 5: zero seed
        cycle(0, 1, 0, 0, g);
        check("t5_zero", 32'(rnd), 32'h0);
        for (int i = 0; i < 8; i++) cycle(0, 0, 0, 3'b111, g);
`ifndef C_PRNG_SHARE_LOCKUP_EN
        check("t5_stuck", 32'(rnd), 32'h0);
`endif

        // 6: reset in RUN while granting, then the test-1 sequence again
        cycle(1, 0, 0, 0, g);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, g);
        cycle(0, 0, 0, 3'b111, g);
        cycle(0, 0, 0, 3'b111, g);
        cycle(1, 0, 0, 3'b111, g);
        check("t6_gnt_rst", g, 32'h0);
        check("t6_rnd_rst", 32'(rnd), 32'hF);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 0, 3'b111, g);
            check("t6_warm_ready", 32'(ready), 32'h0);
        end
        cycle(0, 0, 0, 3'b111, g);
        check("t6_ready", 32'(ready), 32'h1);
        check("t6_rnd", 32'(rnd), 32'h8);

        // random traffic with occasional reseeds and resets
        for (int i = 0; i < 400; i++) begin
            bit r;
            bit s;
            r = ($urandom_range(0, 59) == 0);
            s = ($urandom_range(0, 19) == 0);
            cycle(r, s, int'($urandom_range(0, 15)), int'($urandom_range(0, 7)), g);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
